// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per cycle, registered result and a one-cycle done pulse.
// Define SHIFT_RIGHT_ARITH_EN to enable sign fill when arith=1; otherwise every shift is logical.
module shift_right_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [NUM_WIDTH-1:0]  bitnum,
  input  logic                  arith,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] workReg_q, workReg_d;
  logic [NUM_WIDTH-1:0]  count_q,   count_d;
  logic [DATA_WIDTH-1:0] out_q,     out_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  arith_q,   arith_d;
  logic                  fillBit;

`ifdef SHIFT_RIGHT_ARITH_EN
  // The working MSB still holds the captured sign bit while sign filling.
  assign fillBit = arith_q & workReg_q[DATA_WIDTH-1];
  assign arith_d = (state_q == IDLE && start) ? arith : arith_q;
`else
  logic unusedArith;
  assign unusedArith = arith;
  assign fillBit     = 1'b0;
  assign arith_d     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    workReg_d = workReg_q;
    count_d   = count_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          workReg_d = in;
          count_d   = bitnum;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          workReg_d = {fillBit, workReg_q[DATA_WIDTH-1:1]};
          count_d   = count_q - {{(NUM_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          out_d   = workReg_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over any start presented at the same edge and aborts an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      workReg_q <= '0;
      count_q   <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arith_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      workReg_q <= workReg_d;
      count_q   <= count_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arith_q   <= arith_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed, table-driven bench for shift_right_seq plus hand-written reset and re-start sequences.
// Expected sign-fill results depend on whether SHIFT_RIGHT_ARITH_EN is defined for the build.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [4:0]  bitnum;
  logic        arith;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] opIn;
    logic [4:0]  opNum;
    logic        opArith;
    logic [31:0] expOut;
  } vec_t;

  shift_right_seq #(.DATA_WIDTH(32), .NUM_WIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in),
    .bitnum (bitnum),
    .arith  (arith),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives start in cycle 0 (called just after a negedge) and watches cycles 1..40.
  task automatic applyStimulus(input vec_t v, input int secondCycle, input logic [31:0] secondIn,
                               output int doneCyc, output int doneCnt,
                               output logic [31:0] outAtDone, output int busyBad,
                               output logic [31:0] outHeld);
    logic expBusy;
    doneCyc   = -1;
    doneCnt   = 0;
    busyBad   = 0;
    outAtDone = 'x;
    start  = 1'b1;
    in     = v.opIn;
    bitnum = v.opNum;
    arith  = v.opArith;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCnt == 1) begin
          doneCyc   = k;
          outAtDone = out;
        end
      end
      expBusy = (k <= int'(v.opNum) + 2);
      if (busy !== expBusy) busyBad++;
      if (k == secondCycle) begin
        start  = 1'b1;
        in     = secondIn;
        bitnum = 5'd2;
        arith  = 1'b1;
      end else begin
        start  = 1'b0;
        in     = $urandom;
        bitnum = 5'($urandom_range(0, 31));
        arith  = 1'($urandom_range(0, 1));
      end
    end
    outHeld = out;
  endtask

  task automatic runVector(input string name, input vec_t v, input int secondCycle,
                           input logic [31:0] secondIn);
    int          doneCyc, doneCnt, busyBad;
    logic [31:0] outAtDone, outHeld;
    applyStimulus(v, secondCycle, secondIn, doneCyc, doneCnt, outAtDone, busyBad, outHeld);
    checkOutput({name, " doneCycle"}, 32'(doneCyc), 32'(int'(v.opNum) + 2));
    checkOutput({name, " doneCount"}, 32'(doneCnt), 32'd1);
    checkOutput({name, " outAtDone"}, outAtDone, v.expOut);
    checkOutput({name, " busyErrors"}, 32'(busyBad), 32'd0);
    checkOutput({name, " outHeld"}, outHeld, v.expOut);
  endtask

  initial begin
    vec_t vecs[8];
    int   busyCnt, doneCnt;

`ifdef SHIFT_RIGHT_ARITH_EN
    vecs[1] = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
    vecs[4] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000};
`else
    vecs[1] = '{32'h8000_0000, 5'd4,  1'b1, 32'h0800_0000};
    vecs[4] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'h0000_0001};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b1, 32'h4000_0000};
`endif
    vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    vecs[2] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    vecs[3] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001};
    vecs[5] = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF};
    vecs[6] = '{32'hA5A5_A5A5, 5'd16, 1'b0, 32'h0000_A5A5};

    rst    = 1'b1;
    start  = 1'b0;
    in     = 32'hFFFF_FFFF;
    bitnum = 5'd0;
    arith  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset out", out, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i], -1, 32'h0);
    end

    // A second start mid-operation must not disturb the captured operands.
    runVector("restart", '{32'h0F0F_0000, 5'd8, 1'b0, 32'h000F_0F00}, 3, 32'hDEAD_BEEF);

    // Reset arriving in cycle 3 of a 10-bit shift aborts it without a done pulse.
    start  = 1'b1;
    in     = 32'hFFFF_FFFF;
    bitnum = 5'd10;
    arith  = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        checkOutput("midReset busy", 32'(busy), 32'h0);
        checkOutput("midReset out", out, 32'h0);
        checkOutput("midReset done", 32'(done), 32'h0);
        rst = 1'b0;
      end else if (k > 4) begin
        if (busy !== 1'b0) busyCnt++;
        if (done !== 1'b0) doneCnt++;
      end
      if (k == 3) rst = 1'b1;
    end
    checkOutput("midReset laterBusy", 32'(busyCnt), 32'h0);
    checkOutput("midReset laterDone", 32'(doneCnt), 32'h0);

    // Reset and start together: start is dropped.
    rst    = 1'b1;
    start  = 1'b1;
    in     = 32'h1234_5678;
    bitnum = 5'd3;
    @(negedge clk);
    checkOutput("rstStart busy", 32'(busy), 32'h0);
    checkOutput("rstStart done", 32'(done), 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) busyCnt++;
      if (done !== 1'b0) doneCnt++;
    end
    checkOutput("rstStart laterBusy", 32'(busyCnt), 32'h0);
    checkOutput("rstStart laterDone", 32'(doneCnt), 32'h0);
    checkOutput("rstStart out", out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL provide parameter NUM_WIDTH, default 5, the shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, request to begin a shift; sampled only in IDLE.
REQ-006 The block SHALL have port in, input, DATA_WIDTH, the operand; captured on the accepted start.
REQ-007 The block SHALL have port bitnum, input, NUM_WIDTH, the right-shift amount; captured on the accepted start.
REQ-008 The block SHALL have port arith, input, 1, fill select (1 = sign fill, 0 = zero fill); captured on the accepted start.
REQ-009 The block SHALL have port out, output, DATA_WIDTH, the registered result.
REQ-010 The block SHALL have port busy, output, 1, high while in SHIFT or DONE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load in, bitnum and arith into internal registers and enter SHIFT at the same edge.
REQ-014 In SHIFT with count≠0, the block SHALL right-shift the working register by exactly 1 bit per cycle, fill the MSB per the fill rule, and decrement count.
REQ-015 In SHIFT with count=0, the block SHALL copy the working register to out and enter DONE.
REQ-016 In DONE, the block SHALL hold done=1 for exactly one cycle, then return to IDLE.
REQ-017 For start accepted in cycle 0, done SHALL be high in cycle bitnum+2, with out valid in that same cycle.
REQ-018 For bitnum=0, out SHALL equal in, with done in cycle 2.
REQ-019 The block SHALL update out only on entry to DONE and hold it through IDLE until the next result.
REQ-020 The block SHALL ignore start while busy=1; captured operands SHALL NOT change mid-operation.
REQ-021 The block SHALL ignore changes on in, bitnum and arith after capture.
REQ-022 The result SHALL equal in >> bitnum, truncated to DATA_WIDTH bits.
REQ-023 The maximum shift SHALL be 2^NUM_WIDTH−1, which is 31 by default.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL enter IDLE and set out=0, busy=0, done=0 and all internal registers to 0.
REQ-025 When rst=1 arrives mid-operation (SHIFT or DONE), the block SHALL abort the operation and emit no done pulse for it.
REQ-026 When rst and start are both 1 at the same edge, reset SHALL take priority and start SHALL be dropped.

Configuration
REQ-027 The block SHALL use macro SHIFT_RIGHT_ARITH_EN to select fill behaviour.
REQ-028 When SHIFT_RIGHT_ARITH_EN is defined, the block SHALL fill the MSB with the captured operand's bit DATA_WIDTH−1 when arith=1, and with 0 when arith=0.
REQ-029 When SHIFT_RIGHT_ARITH_EN is undefined, the arith port SHALL still exist but be ignored, and all fills SHALL be 0 (logical shift only).

Verification
REQ-030 The bench SHALL check: in=0x80000000, bitnum=4, arith=0, start in cycle 0 -> done=1 in cycle 6 only, out=0x08000000.
REQ-031 The bench SHALL check, with SHIFT_RIGHT_ARITH_EN defined: in=0x80000000, bitnum=4, arith=1 -> out=0xF8000000 in cycle 6; with the macro undefined, the same stimulus -> out=0x08000000.
REQ-032 The bench SHALL check: in=0x12345678, bitnum=0 -> done in cycle 2, out=0x12345678; and in=0xFFFFFFFF, bitnum=31, arith=0 -> done in cycle 33, out=0x00000001.
REQ-033 The bench SHALL check: start in cycle 0 with bitnum=8, then a second start with in=0xDEADBEEF in cycle 3 -> second start ignored, result from the first operand only, busy continuous cycles 1–10.
REQ-034 The bench SHALL check: rst=1 in cycle 3 of a bitnum=10 operation -> from cycle 4, busy=0, out=0, done=0, and no done pulse afterward.
REQ-035 The bench SHALL check: rst=1 and start=1 in the same cycle -> remains IDLE, busy=0 the next cycle.
